univ_shift_reg_n: RTL

UNIV_SHIFT_REG_N -- requirements
Module: univ_shift_reg_n

---
 rtl/univ_shift_reg_n.sv | 115 +++++++++++
 1 files changed

// File: rtl/univ_shift_reg_n.sv
// Universal N-bit shift register with an autonomous burst-shift engine.
// "Right" moves data toward the MSB (serial-in at Q[0]); "left" moves data
// toward the LSB (serial-in at Q[WIDTH-1]).
// WIDTH is legal from 2 to 32, and CNT_W must satisfy 2**CNT_W > WIDTH.
//
// Burst request handshake: Start acts as a one-shot valid.
// - It is accepted on any rising edge where the FSM is IDLE and Len != 0.
//   The IDLE state, exposed as Busy == 0, is the ready indication.
// - Dir and Len are captured on that same edge.
// - Start is ignored while Busy is high, and ignored whenever Len == 0.
// - Completion is reported by a one-cycle Done pulse in the first IDLE cycle.
//   A new Start may be accepted in that same cycle.
module univ_shift_reg_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             Clk,
    input  logic             MR,
    input  logic [2:0]       S,
    input  logic             DSR,
    input  logic             DSL,
    input  logic [WIDTH-1:0] D,
    input  logic             Start,
    input  logic             Dir,
    input  logic [CNT_W-1:0] Len,
    output logic [WIDTH-1:0] Q,
    output logic             SOR,
    output logic             SOL,
    output logic             Busy,
    output logic             Done,
    output logic             fsm_state
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             dir_q;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] shift_l;
    logic [WIDTH-1:0] mode_q;
    logic             start_ok;

    // Serial shift candidates, shared by the mode decoder and the burst engine
    assign shift_r = {Q[WIDTH-2:0], DSR};
    assign shift_l = {DSL, Q[WIDTH-1:1]};

    // A burst is only launched for a non-zero length request
    assign start_ok = Start && (Len != '0);

    // Next register value for the idle-mode operations selected by S
    always_comb begin
        mode_q = Q;
        case (S)
            3'b000:  mode_q = Q;
            3'b001:  mode_q = shift_r;
            3'b010:  mode_q = shift_l;
            3'b011:  mode_q = D;
            3'b100:  mode_q = {Q[WIDTH-2:0], Q[WIDTH-1]};
            3'b101:  mode_q = {Q[0], Q[WIDTH-1:1]};
            3'b110:  mode_q = {Q[WIDTH-1], Q[WIDTH-1:1]};
            3'b111:  mode_q = '0;
            default: mode_q = Q;
        endcase
    end

    // Control FSM plus data register; Done is a registered one-cycle pulse
    always_ff @(posedge Clk or negedge MR) begin
        if (!MR) begin
            state <= IDLE;
            count <= '0;
            dir_q <= 1'b0;
            Q     <= '0;
            Done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (start_ok) begin
                        // Acceptance edge: capture the request and hold Q
                        state <= BURST;
                        count <= Len;
                        dir_q <= Dir;
                    end else begin
                        Q <= mode_q;
                    end
                end
                BURST: begin
                    Q     <= dir_q ? shift_l : shift_r;
                    count <= count - 1'b1;
                    if (count == CNT_W'(1)) begin
                        state <= IDLE;
                        Done  <= 1'b1;
                    end else begin
                        Done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

    // Serial outputs and status are pure decodes of registered state
    assign SOR       = Q[WIDTH-1];
    assign SOL       = Q[0];
    assign Busy      = (state == BURST);
    assign fsm_state = state;

endmodule
